// File: rtl/eth_hdr_pkg.sv
// Shared constants and types for the 10G Ethernet receive header parser.
package eth_hdr_pkg;

  localparam int BEAT_BYTES    = 8;
  localparam int HEAD_BYTES    = 42;
  localparam int HEAD_BEATS    = 6;
  localparam int PAYLOAD_BYTES = 6;
  localparam int CNT_W         = 3;

  // HEAD: collecting header beats; SKIP: discarding the rest of the frame.
  typedef enum logic {
    HEAD = 1'b0,
    SKIP = 1'b1
  } state_e;

endpackage

// File: rtl/eth_lane_to_be.sv
// Reorders an 8-lane stream beat (lane 0 = earliest byte) into big-endian
// byte order so lane 0 lands in the most significant byte.
module eth_lane_to_be
  import eth_hdr_pkg::*;
(
  input  logic [BEAT_BYTES*8-1:0] lanes_i,
  output logic [BEAT_BYTES*8-1:0] be_o
);

  for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
    assign be_o[(BEAT_BYTES-1-gi)*8 +: 8] = lanes_i[gi*8 +: 8];
  end

endmodule

// File: rtl/eth_header_receiver.sv
// Front-end header capture for the 10G Ethernet receive path.
// Captures frame bytes 0..41 big-endian plus the six trailing bytes of the
// sixth beat as early payload, and pulses o_data_head_valid when complete.
// Optional: define ETH_HDR_RUNT_FLAG_EN to add the o_hdr_runt pulse output.
module eth_header_receiver
  import eth_hdr_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int HEAD_BYTES = 42
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_rx_axis_tvalid,
  input  logic [DATA_W-1:0]         i_rx_axis_tdata,
  input  logic                      i_rx_axis_tlast,
  input  logic [DATA_W/8-1:0]       i_rx_axis_tkeep,
  output logic [HEAD_BYTES*8-1:0]   o_data_head,
  output logic                      o_data_head_valid,
  output logic                      o_data_head_frame_payload_valid,
  output logic [PAYLOAD_BYTES*8-1:0] o_data_head_frame_payload,
  output logic [PAYLOAD_BYTES-1:0]  o_data_head_frame_payload_keep
`ifdef ETH_HDR_RUNT_FLAG_EN
  ,
  output logic                      o_hdr_runt
`endif
);

  localparam logic [CNT_W-1:0] LAST_HEAD_BEAT = CNT_W'(HEAD_BEATS - 1);

  state_e                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [HEAD_BYTES*8-1:0]    head_q;
  logic                       head_valid_q;
  logic                       payload_valid_q;
  logic [PAYLOAD_BYTES*8-1:0] payload_q;
  logic [PAYLOAD_BYTES-1:0]   keep_q;
  logic [DATA_W-1:0]          beat_be;
  logic                       unused_keep_lo;
`ifdef ETH_HDR_RUNT_FLAG_EN
  logic                       runt_q;
`endif

  // Only lanes 2..7 of the sixth beat carry payload enables; lanes 0..1
  // are always header bytes and their keep bits carry no information.
  assign unused_keep_lo = ^i_rx_axis_tkeep[1:0];

  eth_lane_to_be u_lane_to_be (
    .lanes_i (i_rx_axis_tdata),
    .be_o    (beat_be)
  );

  // Beat-counting FSM: fills the header for beats 0..5, then skips to tlast.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= HEAD;
      cnt_q           <= '0;
      head_q          <= '0;
      head_valid_q    <= 1'b0;
      payload_valid_q <= 1'b0;
      payload_q       <= '0;
      keep_q          <= '0;
`ifdef ETH_HDR_RUNT_FLAG_EN
      runt_q          <= 1'b0;
`endif
    end else begin
      head_valid_q    <= 1'b0;
      payload_valid_q <= 1'b0;
`ifdef ETH_HDR_RUNT_FLAG_EN
      runt_q          <= 1'b0;
`endif
      if (i_rx_axis_tvalid) begin
        case (state_q)
          HEAD: begin
            if (cnt_q == LAST_HEAD_BEAT) begin
              // Lanes 0..1 close the header; lanes 2..7 are early payload.
              head_q[15:8]    <= i_rx_axis_tdata[7:0];
              head_q[7:0]     <= i_rx_axis_tdata[15:8];
              payload_q       <= i_rx_axis_tdata[DATA_W-1:16];
              keep_q          <= i_rx_axis_tkeep[DATA_W/8-1:2];
              payload_valid_q <= |i_rx_axis_tkeep[DATA_W/8-1:2];
              head_valid_q    <= 1'b1;
              cnt_q           <= '0;
              state_q         <= i_rx_axis_tlast ? HEAD : SKIP;
            end else begin
              // Full beats land whole; tkeep is deliberately ignored here.
              for (int k = 0; k < HEAD_BEATS - 1; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                  head_q[HEAD_BYTES*8-1-k*BEAT_BYTES*8 -: BEAT_BYTES*8] <= beat_be;
                end
              end
              if (i_rx_axis_tlast) begin
                cnt_q <= '0;
`ifdef ETH_HDR_RUNT_FLAG_EN
                runt_q <= 1'b1;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          SKIP: begin
            if (i_rx_axis_tlast) begin
              state_q <= HEAD;
            end
          end
          default: state_q <= HEAD;
        endcase
      end
    end
  end

  assign o_data_head                     = head_q;
  assign o_data_head_valid               = head_valid_q;
  assign o_data_head_frame_payload_valid = payload_valid_q;
  assign o_data_head_frame_payload       = payload_q;
  assign o_data_head_frame_payload_keep  = keep_q;
`ifdef ETH_HDR_RUNT_FLAG_EN
  assign o_hdr_runt                      = runt_q;
`endif

endmodule

// File: tb/tb_eth_header_receiver.sv
// Directed self-checking bench for eth_header_receiver.
module tb_eth_header_receiver;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         tvalid;
  logic [63:0]  tdata;
  logic         tlast;
  logic [7:0]   tkeep;
  logic [335:0] o_data_head;
  logic         o_data_head_valid;
  logic         o_pv;
  logic [47:0]  o_payload;
  logic [5:0]   o_keep;
`ifdef ETH_HDR_RUNT_FLAG_EN
  logic         o_hdr_runt;
`endif

  always #5 i_clk = ~i_clk;

  eth_header_receiver dut (
    .i_clk                           (i_clk),
    .i_reset                         (i_reset),
    .i_rx_axis_tvalid                (tvalid),
    .i_rx_axis_tdata                 (tdata),
    .i_rx_axis_tlast                 (tlast),
    .i_rx_axis_tkeep                 (tkeep),
    .o_data_head                     (o_data_head),
    .o_data_head_valid               (o_data_head_valid),
    .o_data_head_frame_payload_valid (o_pv),
    .o_data_head_frame_payload       (o_payload),
    .o_data_head_frame_payload_keep  (o_keep)
`ifdef ETH_HDR_RUNT_FLAG_EN
    ,
    .o_hdr_runt                      (o_hdr_runt)
`endif
  );

  logic [7:0]  fr [0:127];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          hv_count;
  int          hv_beat;
  int          hv_next_beat;
  int          prev_beat;
  int          runt_count;
  logic        pv_hist   [0:7];
  logic [5:0]  keep_hist [0:7];
  logic [47:0] dst_hist  [0:7];

  task automatic chk(input string tag, input logic [335:0] obs, input logic [335:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hv_count     = 0;
    hv_beat      = -1;
    hv_next_beat = -2;
    runt_count   = 0;
  endtask

  function automatic logic [335:0] exp_head();
    logic [335:0] h;
    for (int i = 0; i < 42; i++) h[335-8*i -: 8] = fr[i];
    return h;
  endfunction

  function automatic logic [47:0] exp_payload();
    logic [47:0] p;
    for (int i = 0; i < 6; i++) p[8*i +: 8] = fr[42+i];
    return p;
  endfunction

  task automatic build_icmp(input logic [47:0] dst);
    for (int i = 0; i < 128; i++) fr[i] = 8'(i);
    for (int i = 0; i < 6; i++) fr[i] = dst[47-8*i -: 8];
    fr[6]=8'h00; fr[7]=8'h11; fr[8]=8'h22; fr[9]=8'h33; fr[10]=8'h44; fr[11]=8'h55;
    fr[12]=8'h08; fr[13]=8'h00; fr[14]=8'h45; fr[15]=8'h00; fr[16]=8'h00; fr[17]=8'h54;
    fr[18]=8'h12; fr[19]=8'h34; fr[20]=8'h40; fr[21]=8'h00; fr[22]=8'h40; fr[23]=8'h01;
    fr[24]=8'h00; fr[25]=8'h00; fr[26]=8'hc0; fr[27]=8'h00; fr[28]=8'h01; fr[29]=8'h02;
    fr[30]=8'hc0; fr[31]=8'h00; fr[32]=8'h01; fr[33]=8'h86; fr[34]=8'h08; fr[35]=8'h00;
    fr[36]=8'hf7; fr[37]=8'hff; fr[38]=8'h00; fr[39]=8'h01; fr[40]=8'h00; fr[41]=8'h01;
  endtask

  task automatic build_arp(input logic [47:0] dst);
    for (int i = 0; i < 128; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) fr[i] = dst[47-8*i -: 8];
    fr[6]=8'h00; fr[7]=8'h11; fr[8]=8'h22; fr[9]=8'h33; fr[10]=8'h44; fr[11]=8'h55;
    fr[12]=8'h08; fr[13]=8'h06; fr[15]=8'h01; fr[16]=8'h08; fr[18]=8'h06; fr[19]=8'h04;
    fr[21]=8'h01; fr[22]=8'h00; fr[23]=8'h11; fr[24]=8'h22; fr[25]=8'h33; fr[26]=8'h44;
    fr[27]=8'h55; fr[28]=8'hc0; fr[29]=8'h00; fr[30]=8'h01; fr[31]=8'h02;
    fr[38]=8'hc0; fr[39]=8'h00; fr[40]=8'h01; fr[41]=8'h86;
  endtask

  // Observe outputs produced by the previous rising edge.
  task automatic sample(output logic saw_hv);
    saw_hv = 1'b0;
    if (o_data_head_valid === 1'b1) begin
      saw_hv = 1'b1;
      if (hv_count < 8) begin
        pv_hist[hv_count]   = o_pv;
        keep_hist[hv_count] = o_keep;
        dst_hist[hv_count]  = o_data_head[335:288];
      end
      hv_count++;
      hv_beat = prev_beat;
    end
`ifdef ETH_HDR_RUNT_FLAG_EN
    if (o_hdr_runt === 1'b1) runt_count++;
`endif
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic l,
                      input logic [7:0] k, input int idx);
    logic saw;
    @(negedge i_clk);
    sample(saw);
    tvalid = v; tdata = d; tlast = l; tkeep = k;
    if (saw) hv_next_beat = idx;
    prev_beat = idx;
  endtask

  task automatic idle();
    step(1'b0, 64'h0, 1'b0, 8'h00, -1);
  endtask

  task automatic send_beat(input int b, input int len);
    logic [63:0] d;
    logic [7:0]  k;
    d = '0; k = '0;
    for (int j = 0; j < 8; j++) begin
      if (8*b + j < len) begin
        d[8*j +: 8] = fr[8*b+j];
        k[j] = 1'b1;
      end
    end
    step(1'b1, d, (8*b + 8 >= len), k, b);
  endtask

  task automatic send_frame(input int len, input int stall);
    int nb;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      send_beat(b, len);
      for (int s = 0; s < stall; s++) idle();
    end
    $display("frame len=%0d stall=%0d beats=%0d head_valid_so_far=%0d", len, stall, nb, hv_count);
  endtask

  initial begin
    i_reset = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tkeep = '0;
    prev_beat = -1;
    clr();

    // Reset state
    #12;
    chk("reset_head", o_data_head, '0);
    chk("reset_hv", o_data_head_valid, 1'b0);
    chk("reset_pv", o_pv, 1'b0);
    chk("reset_payload", o_payload, '0);
    chk("reset_keep", o_keep, '0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // ARP broadcast, 60 bytes
    build_arp(48'hffffffffffff); clr();
    send_frame(60, 0); idle(); idle();
    chk("arp_dst", o_data_head[335:288], 48'hffffffffffff);
    chk("arp_type", o_data_head[239:224], 16'h0806);
    chk("arp_tpa", o_data_head[31:0], 32'hc0000186);
    chk("arp_head", o_data_head, exp_head());
    chk("arp_hv_count", hv_count, 1);
    chk("arp_hv_beat", hv_beat, 5);
    chk("arp_keep", o_keep, 6'h3f);
    chk("arp_pv", pv_hist[0], 1'b1);

    // ICMP echo, 98 bytes, back-to-back
    build_icmp(48'h02aabbccddee); clr();
    send_frame(98, 0); idle(); idle();
    chk("icmp_type_byte34", o_data_head[63:56], 8'h08);
    chk("icmp_payload_b42", o_payload[7:0], 8'h2a);
    chk("icmp_payload", o_payload, 48'h2f2e2d2c2b2a);
    chk("icmp_head", o_data_head, exp_head());
    chk("icmp_hv_count", hv_count, 1);
    chk("icmp_hv_beat", hv_beat, 5);
    chk("icmp_beat6_align", hv_next_beat, 6);
    chk("icmp_keep", o_keep, 6'h3f);
    chk("icmp_idle_hv", o_data_head_valid, 1'b0);
    chk("icmp_idle_pv", o_pv, 1'b0);

    // Stall insertion
    build_icmp(48'h02aabbccddef); clr();
    send_frame(98, 3); idle();
    chk("stall_head", o_data_head, exp_head());
    chk("stall_payload", o_payload, exp_payload());
    chk("stall_hv_count", hv_count, 1);
    chk("stall_hv_beat", hv_beat, 5);

    // Runt, tlast on beat 3, then a full frame
    build_icmp(48'h0266778899aa); clr();
    send_frame(28, 0); idle(); idle();
    chk("runt_no_hv", hv_count, 0);
`ifdef ETH_HDR_RUNT_FLAG_EN
    chk("runt_flag", runt_count, 1);
`endif
    build_arp(48'h0a0b0c0d0e0f); clr();
    send_frame(60, 0); idle();
    chk("post_runt_head", o_data_head, exp_head());
    chk("post_runt_hv", hv_count, 1);

    // 42-byte frame (tlast on beat 5, no payload) followed directly by ARP
    build_icmp(48'h0211223344ff); clr();
    send_frame(42, 0);
    build_arp(48'hffffffffffff);
    send_frame(60, 0); idle();
    chk("short_hv_count", hv_count, 2);
    chk("short_pv", pv_hist[0], 1'b0);
    chk("short_keep", keep_hist[0], 6'h00);
    chk("short_dst", dst_hist[0], 48'h0211223344ff);
    chk("short_next_head", o_data_head, exp_head());

    // Two full frames back-to-back
    build_arp(48'hffffffffffff); clr();
    send_frame(60, 0);
    build_icmp(48'h211abcdef112);
    send_frame(98, 0); idle();
    chk("b2b_hv_count", hv_count, 2);
    chk("b2b_dst0", dst_hist[0], 48'hffffffffffff);
    chk("b2b_dst1", dst_hist[1], 48'h211abcdef112);
    chk("b2b_head", o_data_head, exp_head());

    // Asynchronous reset during beat 2
    build_icmp(48'h02aabbccddee); clr();
    send_beat(0, 98); send_beat(1, 98); send_beat(2, 98);
    #2 i_reset = 1'b1;
    #1;
    chk("areset_head", o_data_head, '0);
    chk("areset_payload", o_payload, '0);
    chk("areset_keep", o_keep, '0);
    @(negedge i_clk);
    tvalid = 1'b0; tlast = 1'b0; i_reset = 1'b0; prev_beat = -1;
    build_icmp(48'h211abcdef112); clr();
    send_frame(98, 0); idle();
    chk("areset_next_head", o_data_head, exp_head());
    chk("areset_next_hv", hv_count, 1);
    chk("areset_next_beat", hv_beat, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
